// File: rtl/uart_stream_bridge.sv
// rtl/uart_stream_bridge.sv - byte stream to 16550-style UART bridge over an APB master port.
// Programs the divisor and line control once after reset, then polls LSR to move bytes.
module uart_stream_bridge #(
  parameter logic [15:0] BAUD_DIV     = 16'd54,
  parameter logic [7:0]  LCR_VAL      = 8'h03,
  parameter logic [7:0]  ADDR_RBR_THR = 8'h00,
  parameter logic [7:0]  ADDR_DLM     = 8'h01,
  parameter logic [7:0]  ADDR_LCR     = 8'h03,
  parameter logic [7:0]  ADDR_LSR     = 8'h05
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       cfg_done_o,
  output logic       err_o,
  input  logic       err_clr_i,
  output logic       m_apb_psel_o,
  output logic       m_apb_penable_o,
  output logic [7:0] m_apb_paddr_o,
  output logic       m_apb_pwrite_o,
  output logic [7:0] m_apb_pwdata_o,
  input  logic [7:0] m_apb_prdata_i,
  input  logic       m_apb_pready_i
);

  typedef enum logic [1:0] {ST_CFG, ST_POLL, ST_RX_RD, ST_TX_WR} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  state_t     r_state, w_state_nxt;
  phase_t     r_phase, w_phase_nxt;
  logic [1:0] r_step, w_step_nxt;
  logic [7:0] r_thr;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_err;

  logic       w_done;
  logic       w_psel;
  logic [7:0] w_addr;
  logic       w_wr;
  logic [7:0] w_wdata;

  assign w_done = (r_phase == PH_ACCESS) && m_apb_pready_i;
  assign w_psel = (r_phase != PH_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_CFG;
      r_phase <= PH_IDLE;
      r_step  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Transfers run back to back; only the first one after reset gets an idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_step_nxt  = r_step;
    case (r_phase)
      PH_IDLE:  w_phase_nxt = PH_SETUP;
      PH_SETUP: w_phase_nxt = PH_ACCESS;
      PH_ACCESS: begin
        if (m_apb_pready_i) begin
          w_phase_nxt = PH_SETUP;
          case (r_state)
            ST_CFG: begin
              if (r_step == 2'd3) begin
                w_state_nxt = ST_POLL;
                w_step_nxt  = 2'd0;
              end else begin
                w_step_nxt = r_step + 2'd1;
              end
            end
            ST_POLL: begin
              if (m_apb_prdata_i[0] && !r_rx_valid)
                w_state_nxt = ST_RX_RD;
              else if (m_apb_prdata_i[5] && tx_valid_i)
                w_state_nxt = ST_TX_WR;
              else
                w_state_nxt = ST_POLL;
            end
            default: w_state_nxt = ST_POLL;
          endcase
        end
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  always_comb begin
    w_addr  = 8'h00;
    w_wr    = 1'b0;
    w_wdata = 8'h00;
    case (r_state)
      ST_CFG: begin
        w_wr = 1'b1;
        case (r_step)
          2'd0: begin w_addr = ADDR_LCR;     w_wdata = 8'h80;          end
          2'd1: begin w_addr = ADDR_RBR_THR; w_wdata = BAUD_DIV[7:0];  end
          2'd2: begin w_addr = ADDR_DLM;     w_wdata = BAUD_DIV[15:8]; end
          default: begin w_addr = ADDR_LCR;  w_wdata = LCR_VAL;        end
        endcase
      end
      ST_POLL:  w_addr = ADDR_LSR;
      ST_RX_RD: w_addr = ADDR_RBR_THR;
      default: begin
        w_addr  = ADDR_RBR_THR;
        w_wr    = 1'b1;
        w_wdata = (r_phase == PH_SETUP) ? tx_data_i : r_thr;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_thr      <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (r_phase == PH_SETUP && r_state == ST_TX_WR)
        r_thr <= tx_data_i;
      if (w_done && r_state == ST_RX_RD) begin
        r_rx_data  <= m_apb_prdata_i;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
      // A line error seen in the same cycle as a clear request must not be lost.
      if (w_done && r_state == ST_POLL && (m_apb_prdata_i[4:1] != 4'd0))
        r_err <= 1'b1;
      else if (err_clr_i)
        r_err <= 1'b0;
    end
  end

  assign m_apb_psel_o    = w_psel;
  assign m_apb_penable_o = (r_phase == PH_ACCESS);
  assign m_apb_paddr_o   = w_psel ? w_addr : 8'h00;
  assign m_apb_pwrite_o  = w_psel & w_wr;
  assign m_apb_pwdata_o  = w_psel ? w_wdata : 8'h00;

  assign tx_ready_o = w_done && (r_state == ST_TX_WR);
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign cfg_done_o = (r_state != ST_CFG);
  assign err_o      = r_err;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb/tb_uart_stream_bridge.sv - self-checking bench for uart_stream_bridge.
// A transfer log from a passive APB slave is judged against the LSR polling rules.
module tb_uart_stream_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       cfg_done;
  logic       err;
  logic       err_clr;
  logic       psel, penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  logic [7:0] lsr_val, rbr_val;
  logic       pready_en;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] data;
    logic       txv;
    logic [7:0] txd;
  } xfer_t;

  xfer_t      log_q[$];
  logic [7:0] rx_obs[$];
  int         tx_pulses = 0;

  always #5 clk = ~clk;

  assign pready = pready_en;
  assign prdata = (paddr == 8'h05) ? lsr_val : ((paddr == 8'h00) ? rbr_val : 8'h5A);

  uart_stream_bridge dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .cfg_done_o(cfg_done), .err_o(err), .err_clr_i(err_clr),
    .m_apb_psel_o(psel), .m_apb_penable_o(penable), .m_apb_paddr_o(paddr),
    .m_apb_pwrite_o(pwrite), .m_apb_pwdata_o(pwdata),
    .m_apb_prdata_i(prdata), .m_apb_pready_i(pready)
  );

  always @(negedge clk) begin
    if (psel && penable && pready)
      log_q.push_back('{paddr, pwrite, (pwrite ? pwdata : prdata), tx_valid, tx_data});
    if (rx_valid && rx_ready)
      rx_obs.push_back(rx_data);
    if (tx_ready)
      tx_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg_seq(input string tag, input int base);
    logic [7:0] ea[4];
    logic [7:0] ed[4];
    ea = '{8'h03, 8'h00, 8'h01, 8'h03};
    ed = '{8'h80, 8'h36, 8'h00, 8'h03};
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_%0d", tag, k),
          {log_q[base+k].addr, log_q[base+k].wr, log_q[base+k].data},
          {ea[k], 1'b1, ed[k]});
  endtask

  initial begin
    int base, rx_base, tx_base, cnt, pulses, seen;
    logic exp_err;
    logic [8:0] exp_kind;
    logic [7:0] rd_bytes[$];
    xfer_t a, b;

    rst_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    lsr_val = 8'h00; rbr_val = 8'h00; pready_en = 1'b1;
    repeat (3) tick();
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 19'h0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx", {rx_valid, rx_data}, 9'h0);
    chk("rst_err_cfg", {err, cfg_done}, 2'b00);

    // Configuration sequence after reset release.
    rst_n = 1'b1;
    base = log_q.size();
    seen = 0;
    cnt = 0;
    while (log_q.size() < base + 4 && cnt < 60) begin
      if (cfg_done) seen = 1;
      tick();
      cnt++;
    end
    chk("cfg_done_early", seen, 0);
    chk("cfg_count", log_q.size() >= base + 4, 1'b1);
    if (log_q.size() >= base + 4) check_cfg_seq("cfg", base);
    chk("cfg_done", cfg_done, 1'b1);

    // Single TX byte.
    lsr_val = 8'h20; tx_data = 8'hA5; tx_valid = 1'b1;
    base = log_q.size();
    pulses = 0;
    cnt = 0;
    while (cnt < 60) begin
      tick();
      cnt++;
      if (tx_ready) begin
        pulses++;
        chk("thr_apb", {penable, pwrite, paddr, pwdata}, {1'b1, 1'b1, 8'h00, 8'hA5});
      end else if (pulses > 0) begin
        break;
      end
    end
    tx_valid = 1'b0;
    chk("tx_pulse_len", pulses, 1);
    cnt = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].wr) begin
        cnt++;
        chk("thr_write", {log_q[i].addr, log_q[i].data}, {8'h00, 8'hA5});
      end
    chk("thr_write_count", cnt, 1);

    // RX has priority over TX; TX follows once the RX holding is full.
    lsr_val = 8'h21; rbr_val = 8'h3C; tx_data = 8'h5A; tx_valid = 1'b1; rx_ready = 1'b0;
    base = log_q.size();
    cnt = 0;
    while (!rx_valid && cnt < 60) begin tick(); cnt++; end
    chk("rx_valid_set", rx_valid, 1'b1);
    chk("rx_data_3c", rx_data, 8'h3C);
    a = '0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr != 8'h05) begin a = log_q[i]; break; end
    chk("rx_first", {a.addr, a.wr, a.data}, {8'h00, 1'b0, 8'h3C});
    pulses = 0;
    cnt = 0;
    while (cnt < 60) begin
      tick();
      cnt++;
      if (tx_ready) pulses++;
      else if (pulses > 0) break;
    end
    tx_valid = 1'b0;
    chk("tx_after_rx", pulses, 1);
    chk("rx_hold_stable", {rx_valid, rx_data}, {1'b1, 8'h3C});

    // Full holding register blocks further RBR reads.
    lsr_val = 8'h01;
    base = log_q.size();
    repeat (20) tick();
    cnt = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr == 8'h00 && !log_q[i].wr) cnt++;
    chk("no_rbr_when_full", cnt, 0);
    rbr_val = 8'h77; rx_ready = 1'b1;
    tick();
    chk("rx_drained", rx_valid, 1'b0);
    cnt = 0;
    while (!rx_valid && cnt < 40) begin tick(); cnt++; end
    chk("rx_data_77", {rx_valid, rx_data}, {1'b1, 8'h77});
    lsr_val = 8'h00;
    repeat (10) tick();

    // Sticky error, clear, and set-wins-over-clear.
    lsr_val = 8'h08;
    cnt = 0;
    while (!err && cnt < 40) begin tick(); cnt++; end
    chk("err_set", err, 1'b1);
    lsr_val = 8'h00;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", err, 1'b0);
    repeat (10) tick();
    chk("err_stays_clear", err, 1'b0);
    lsr_val = 8'h08; err_clr = 1'b1;
    seen = 0;
    repeat (15) begin tick(); if (err) seen = 1; end
    chk("err_set_wins", seen, 1);
    lsr_val = 8'h00;
    repeat (4) tick();
    err_clr = 1'b0;
    chk("err_clr_held", err, 1'b0);

    // Stalled pready holds the LSR poll unchanged.
    pready_en = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_%0d", k), {psel, penable, pwrite, paddr, pwdata},
          {1'b1, 1'b1, 1'b0, 8'h05, 8'h00});
      tick();
    end
    pready_en = 1'b1;
    repeat (4) tick();

    // Randomised segments checked against the polling rules.
    base = log_q.size();
    rx_base = rx_obs.size();
    tx_base = tx_pulses;
    for (int s = 0; s < 8; s++) begin
      pready_en = 1'b0;
      repeat (3) tick();
      lsr_val = 8'($urandom);
      if ($urandom_range(3) != 0) lsr_val[4:1] = 4'd0;
      rbr_val  = 8'($urandom);
      tx_data  = 8'($urandom);
      tx_valid = 1'($urandom_range(1));
      pready_en = 1'b1;
      repeat (30) tick();
    end
    lsr_val = 8'h00; tx_valid = 1'b0;
    repeat (10) tick();

    exp_err = 1'b0;
    cnt = 0;
    for (int i = base; i + 1 < log_q.size(); i++) begin
      a = log_q[i];
      b = log_q[i+1];
      if (a.addr == 8'h05 && !a.wr) begin
        exp_err = exp_err | (a.data[4:1] != 4'd0);
        if (a.data[0])                exp_kind = {8'h00, 1'b0};
        else if (a.data[5] && a.txv)  exp_kind = {8'h00, 1'b1};
        else                          exp_kind = {8'h05, 1'b0};
      end else begin
        exp_kind = {8'h05, 1'b0};
      end
      chk($sformatf("seq_%0d", i - base), {b.addr, b.wr}, exp_kind);
      if (exp_kind == {8'h00, 1'b1}) chk($sformatf("seq_thr_%0d", i - base), b.data, a.txd);
    end
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].addr == 8'h00 && !log_q[i].wr) rd_bytes.push_back(log_q[i].data);
      if (log_q[i].wr) cnt++;
    end
    chk("rand_err", err, exp_err);
    chk("rand_tx_pulses", tx_pulses - tx_base, cnt);
    chk("rand_rx_count", rx_obs.size() - rx_base, rd_bytes.size());
    for (int k = 0; k < rd_bytes.size() && rx_base + k < rx_obs.size(); k++)
      chk($sformatf("rand_rx_%0d", k), rx_obs[rx_base+k], rd_bytes[k]);

    // Reset during the THR access phase.
    lsr_val = 8'h20; tx_data = 8'hC3; tx_valid = 1'b1;
    cnt = 0;
    while (!(psel && !penable && pwrite) && cnt < 60) begin tick(); cnt++; end
    pready_en = 1'b0;
    tick();
    chk("thr_stalled", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b1, 1'b1, 8'h00, 8'hC3});
    tx_base = tx_pulses;
    rst_n = 1'b0;
    pready_en = 1'b1;
    #1;
    chk("rst_mid_apb", {psel, penable, pwrite, paddr, pwdata}, 19'h0);
    chk("rst_mid_out", {tx_ready, rx_valid, rx_data, err, cfg_done}, 12'h0);
    repeat (2) tick();
    chk("rst_no_tx_pulse", tx_pulses - tx_base, 0);
    rst_n = 1'b1;
    base = log_q.size();
    cnt = 0;
    while (log_q.size() < base + 4 && cnt < 60) begin tick(); cnt++; end
    chk("recfg_count", log_q.size() >= base + 4, 1'b1);
    if (log_q.size() >= base + 4) check_cfg_seq("recfg", base);
    tx_valid = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
